// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined WIDTH-bit ALU with carry/zero flags and
//               valid/ready handshakes on input and output. Stage 1 registers
//               operands and opcode; stage 2 registers the computed result.
//               Optional feature macro: ALU_ACC_EN (opcode 7 becomes ACC,
//               result = acc + ain, acc tracks the last ACC result).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int OP_W  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic [OP_W-1:0]  sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] zout,
   output logic             carry,
   output logic             zero
);

   localparam logic [OP_W-1:0] c_OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] c_OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] c_OP_XOR  = 3'd2;
   localparam logic [OP_W-1:0] c_OP_XNOR = 3'd3;
   localparam logic [OP_W-1:0] c_OP_NAND = 3'd4;
   localparam logic [OP_W-1:0] c_OP_ADD  = 3'd5;
   localparam logic [OP_W-1:0] c_OP_SUB  = 3'd6;

   // Stage 1 holding registers
   logic             r_s1_v;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [OP_W-1:0]  r_sel;

   // Stage 2 result registers
   logic             r_s2_v;
   logic [WIDTH-1:0] r_z;
   logic             r_c;
   logic             r_zero;

   // Handshake / advance controls
   logic w_s2_adv;
   logic w_s1_adv;
   logic w_accept;

   // Stage 2 datapath results
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_z;
   logic             w_c;

`ifdef ALU_ACC_EN
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH:0]   w_acc_sum;
`endif

   // s2 can take new data when empty or when its current result leaves now
   assign w_s2_adv  = out_ready || !r_s2_v;
   assign w_s1_adv  = r_s1_v && w_s2_adv;
   assign in_ready  = !r_s1_v || w_s2_adv;
   assign w_accept  = in_valid && in_ready;

   assign out_valid = r_s2_v;
   assign zout      = r_z;
   assign carry     = r_c;
   assign zero      = r_zero;

   // Extra MSB captures carry-out (ADD) and borrow (SUB)
   assign w_add = {1'b0, r_a} + {1'b0, r_b};
   assign w_sub = {1'b0, r_a} - {1'b0, r_b};
`ifdef ALU_ACC_EN
   assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_a};
`endif

   // Result and carry selection from the stage-1 registers
   always_comb begin
      w_z = r_a;
      w_c = 1'b0;
      case (r_sel)
         c_OP_AND:  w_z = r_a & r_b;
         c_OP_OR:   w_z = r_a | r_b;
         c_OP_XOR:  w_z = r_a ^ r_b;
         c_OP_XNOR: w_z = ~(r_a ^ r_b);
         c_OP_NAND: w_z = ~(r_a & r_b);
         c_OP_ADD: begin
            w_z = w_add[WIDTH-1:0];
            w_c = w_add[WIDTH];
         end
         c_OP_SUB: begin
            w_z = w_sub[WIDTH-1:0];
            w_c = w_sub[WIDTH];
         end
         default: begin
`ifdef ALU_ACC_EN
            w_z = w_acc_sum[WIDTH-1:0];
            w_c = w_acc_sum[WIDTH];
`else
            w_z = r_a;
            w_c = 1'b0;
`endif
         end
      endcase
   end

   // Stage 1: load on accept; drop valid only when emptied without a refill
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
         r_sel  <= '0;
      end else if (w_accept) begin
         r_s1_v <= 1'b1;
         r_a    <= ain;
         r_b    <= bin;
         r_sel  <= sel;
      end else if (w_s1_adv) begin
         r_s1_v <= 1'b0;
      end
   end

   // Stage 2: capture result when s1 advances; clear valid on a bare transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_v <= 1'b0;
         r_z    <= '0;
         r_c    <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_v <= 1'b1;
         r_z    <= w_z;
         r_c    <= w_c;
         r_zero <= (w_z == '0);
      end else if (out_ready) begin
         r_s2_v <= 1'b0;
      end
   end

`ifdef ALU_ACC_EN
   // Accumulator follows each ACC result at the same edge s2 captures it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_s1_adv && (r_sel == 3'd7)) begin
         r_acc <= w_acc_sum[WIDTH-1:0];
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Scoreboard bench for alu_pipe. Driver pushes the expected
//               {zout,carry,zero} on accept; a monitor pops on every output
//               transfer. Build with ALU_ACC_EN to exercise the ACC opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic [2:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] zout;
   logic             carry;
   logic             zero;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH+1:0] sb[$];

   alu_pipe #(.WIDTH(WIDTH), .OP_W(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ain      (ain),
      .bin      (bin),
      .sel      (sel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .zout     (zout),
      .carry    (carry),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Present one op starting at posedge+1; returns at posedge+1 after the accept
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic [WIDTH-1:0] ez, input logic ec);
      int n;
      n = 0;
      ain = a; bin = b; sel = op; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=in_ready0 expected=in_ready1");
      end else begin
         sb.push_back({ez, ec, (ez == '0)});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Monitor: compare each transferred result against the scoreboard head
   always @(negedge clk) begin
      logic [WIDTH+1:0] e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_result actual=%0h expected=none", zout);
         end else begin
            e = sb.pop_front();
            chk("result_zout",  {24'd0, zout}, {24'd0, e[WIDTH+1:2]});
            chk("result_carry", {31'd0, carry}, {31'd0, e[1]});
            chk("result_zero",  {31'd0, zero},  {31'd0, e[0]});
         end
      end
   end

   task automatic latency_add;
      issue(8'hF0, 8'h20, 3'd5, 8'h10, 1'b1);
      @(negedge clk);
      chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_cycle2_zout",  {24'd0, zout}, 32'h10);
      chk("lat_cycle2_carry", {31'd0, carry}, 32'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; ain = '0; bin = '0; sel = '0; out_ready = 1'b1;
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_zout",      {24'd0, zout}, 32'd0);
      chk("reset_flags",     {30'd0, carry, zero}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // ADD with latency check
      latency_add();

      // SUB cases
      @(posedge clk); #1;
      issue(8'h05, 8'h05, 3'd6, 8'h00, 1'b0);
      issue(8'h03, 8'h04, 3'd6, 8'hFF, 1'b1);

      // Logic sweep, back to back
      issue(8'hCC, 8'hAA, 3'd0, 8'h88, 1'b0);
      issue(8'hCC, 8'hAA, 3'd1, 8'hEE, 1'b0);
      issue(8'hCC, 8'hAA, 3'd2, 8'h66, 1'b0);
      issue(8'hCC, 8'hAA, 3'd3, 8'h99, 1'b0);
      issue(8'hCC, 8'hAA, 3'd4, 8'h77, 1'b0);
      issue(8'hFF, 8'h02, 3'd5, 8'h01, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: two fill the pipe, third must wait
      out_ready = 1'b0;
      issue(8'h01, 8'h01, 3'd5, 8'h02, 1'b0);
      issue(8'h0F, 8'hFF, 3'd2, 8'hF0, 1'b0);
      fork
         issue(8'h00, 8'hFF, 3'd0, 8'h00, 1'b0);
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("stall_in_ready",  {31'd0, in_ready}, 32'd0);
               chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
               chk("stall_zout",      {24'd0, zout}, 32'h02);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("drain_no_gap", {31'd0, out_valid}, 32'd1);
            end
         end
      join
      repeat (2) @(posedge clk);
      #1;

      // Reset while both stages are full
      out_ready = 1'b0;
      issue(8'h11, 8'h22, 3'd5, 8'h33, 1'b0);
      issue(8'h44, 8'h11, 3'd6, 8'h33, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_zout",      {24'd0, zout}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      latency_add();
      @(posedge clk); #1;

      // Opcode 7: ACC chain or PASS depending on build
`ifdef ALU_ACC_EN
      issue(8'h03, 8'h55, 3'd7, 8'd3,  1'b0);
      issue(8'h04, 8'h55, 3'd7, 8'd7,  1'b0);
      issue(8'h05, 8'h55, 3'd7, 8'd12, 1'b0);
`else
      issue(8'h03, 8'h55, 3'd7, 8'd3, 1'b0);
      issue(8'h04, 8'h55, 3'd7, 8'd4, 1'b0);
      issue(8'h05, 8'h55, 3'd7, 8'd5, 1'b0);
`endif

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
      end
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
